// File: rtl/lf_sub16_pipe.sv
// Two-stage pipelined subtractor (a - b) on a Ladner-Fischer prefix carry tree.
// Stage 1 registers propagate/generate of a + ~b; stage 2 resolves carries and flags.
module lf_sub16_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned LVL = $clog2(WIDTH);

    logic             s1_v_q, s1_v_d;
    logic [WIDTH-1:0] s1_p_q, s1_p_d;
    logic [WIDTH-1:0] s1_g_q, s1_g_d;
    logic             s1_amsb_q, s1_amsb_d;
    logic             s1_bmsb_q, s1_bmsb_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             s2_load;
    logic             accept;
    logic [WIDTH-1:0] gl [LVL+1];
    logic [WIDTH-1:0] pl [LVL+1];
    logic [WIDTH-1:0] gfin;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum;
    int unsigned      j;

    assign s2_load  = s1_v_q & (~out_valid_q | out_ready);
    assign in_ready = ~s1_v_q | s2_load;
    assign accept   = in_valid & in_ready;

    // Carry-in of 1 enters as a grey cell at bit 0; odd columns get the
    // Sklansky-style tree, even columns are finished by one grey row.
    always_comb begin : prefix
        j         = 0;
        gl[0]     = s1_g_q;
        gl[0][0]  = s1_g_q[0] | s1_p_q[0];
        pl[0]     = s1_p_q;
        for (int unsigned k = 0; k < LVL; k++) begin
            gl[k+1] = gl[k];
            pl[k+1] = pl[k];
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if ((i % 2 == 1) && (((i >> k) % 2) == 1)) begin
                    j           = ((i >> k) << k) - 1;
                    gl[k+1][i]  = gl[k][i] | (pl[k][i] & gl[k][j]);
                    pl[k+1][i]  = pl[k][i] & pl[k][j];
                end
            end
        end
        gfin = gl[LVL];
        for (int unsigned i = 2; i < WIDTH; i += 2) begin
            gfin[i] = gl[LVL][i] | (pl[LVL][i] & gl[LVL][i-1]);
        end
        carry = {gfin[WIDTH-2:0], 1'b1};
        sum   = (s1_p_q & ~s1_g_q) ^ carry;
    end

    always_comb begin : next_state
        s1_v_d      = s1_v_q;
        s1_p_d      = s1_p_q;
        s1_g_d      = s1_g_q;
        s1_amsb_d   = s1_amsb_q;
        s1_bmsb_d   = s1_bmsb_q;
        out_valid_d = out_valid_q;
        diff_d      = diff_q;
        borrow_d    = borrow_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;

        if (accept) begin
            s1_v_d    = 1'b1;
            s1_p_d    = a | ~b;
            s1_g_d    = a & ~b;
            s1_amsb_d = a[WIDTH-1];
            s1_bmsb_d = b[WIDTH-1];
        end else if (s2_load) begin
            s1_v_d = 1'b0;
        end

        if (s2_load) begin
            out_valid_d = 1'b1;
            diff_d      = sum;
            borrow_d    = ~gfin[WIDTH-1];
            ovf_d       = (s1_amsb_q ^ s1_bmsb_q) & (sum[WIDTH-1] ^ s1_amsb_q);
            zero_d      = (sum == '0);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            s1_p_q      <= '0;
            s1_g_q      <= '0;
            s1_amsb_q   <= 1'b0;
            s1_bmsb_q   <= 1'b0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_p_q      <= s1_p_d;
            s1_g_q      <= s1_g_d;
            s1_amsb_q   <= s1_amsb_d;
            s1_bmsb_q   <= s1_bmsb_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_lf_sub16_pipe.sv
// Directed and randomized checks of lf_sub16_pipe: flags, latency, stalls, reset.
module tb_lf_sub16_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        borrow;
    logic        ovf;
    logic        zero;
    logic [18:0] res;

    int ntests = 0;
    int nfail  = 0;

    // Directed vectors: {diff, borrow, ovf, zero} worked out by hand
    logic [15:0] va   [6] = '{16'h0005, 16'h0003, 16'h8000, 16'h7FFF, 16'h1234, 16'h0000};
    logic [15:0] vb   [6] = '{16'h0003, 16'h0005, 16'h0001, 16'hFFFF, 16'h1234, 16'h0000};
    logic [18:0] vexp [6] = '{{16'h0002, 3'b000}, {16'hFFFE, 3'b100}, {16'h7FFF, 3'b010},
                              {16'h8000, 3'b110}, {16'h0000, 3'b001}, {16'h0000, 3'b001}};

    lf_sub16_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf),
        .zero      (zero)
    );

    assign res = {diff, borrow, ovf, zero};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        repeat (2) step();
        ntests++;
        if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        ntests++;
        if (res !== 19'h0) begin nfail++; $display("FAIL reset_regs got=%h exp=0", res); end
        rst = 1'b0;
        step();
        ntests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            nfail++; $display("FAIL reset_release in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_vectors();
        for (int n = 0; n < 6; n++) begin
            out_ready = 1'b1;
            in_valid = 1'b1; a = va[n]; b = vb[n];
            step();
            in_valid = 1'b0;
            ntests++;
            if (out_valid !== 1'b0) begin nfail++; $display("FAIL vec%0d_early_valid got=%b exp=0", n, out_valid); end
            step();
            ntests++;
            if (out_valid !== 1'b1) begin nfail++; $display("FAIL vec%0d_latency out_valid=%b exp=1", n, out_valid); end
            ntests++;
            if (res !== vexp[n]) begin nfail++; $display("FAIL vec%0d_result got=%h exp=%h", n, res, vexp[n]); end
            step();
        end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc < 6) begin in_valid = 1'b1; a = va[cyc]; b = vb[cyc]; end
            else in_valid = 1'b0;
            #1;
            if (cyc < 6) begin
                ntests++;
                if (in_ready !== 1'b1) begin nfail++; $display("FAIL b2b_in_ready cyc%0d got=%b exp=1", cyc, in_ready); end
            end
            if (cyc >= 2) begin
                ntests++;
                if (out_valid !== 1'b1 || res !== vexp[cyc-2]) begin
                    nfail++; $display("FAIL b2b_result cyc%0d valid=%b got=%h exp=%h", cyc, out_valid, res, vexp[cyc-2]);
                end
            end
            step();
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [15:0] ba [4] = '{16'h000A, 16'h0003, 16'h8000, 16'hFFFF};
        logic [15:0] bb [4] = '{16'h0003, 16'h000A, 16'h7FFF, 16'hFFFF};
        logic [18:0] be [4] = '{{16'h0007, 3'b000}, {16'hFFF9, 3'b100},
                                {16'h0001, 3'b010}, {16'h0000, 3'b001}};
        int  sent = 0;
        int  got  = 0;
        logic acc;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (sent < 4) begin in_valid = 1'b1; a = ba[sent]; b = bb[sent]; end
            else in_valid = 1'b0;
            if (cyc == 5) out_ready = 1'b1;
            #1;
            if (cyc == 2) begin
                ntests++;
                if (in_ready !== 1'b0 || sent != 2) begin
                    nfail++; $display("FAIL bp_in_ready got=%b accepted=%0d exp=0/2", in_ready, sent);
                end
            end
            if (cyc >= 2 && cyc < 5) begin
                ntests++;
                if (out_valid !== 1'b1 || res !== be[0]) begin
                    nfail++; $display("FAIL bp_hold cyc%0d valid=%b got=%h exp=%h", cyc, out_valid, res, be[0]);
                end
            end
            if (cyc == 5) begin
                ntests++;
                if (in_ready !== 1'b1) begin nfail++; $display("FAIL bp_full_advance in_ready=%b exp=1", in_ready); end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                ntests++;
                if (res !== be[got]) begin nfail++; $display("FAIL bp_order idx%0d got=%h exp=%h", got, res, be[got]); end
                got++;
            end
            acc = in_valid & in_ready;
            step();
            if (acc) sent++;
        end
        ntests++;
        if (got != 4) begin nfail++; $display("FAIL bp_count got=%0d exp=4", got); end
        drain();
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        out_ready = 1'b0;
        for (int n = 0; n < 2; n++) begin
            in_valid = 1'b1; a = va[n]; b = vb[n];
            step();
        end
        in_valid = 1'b0;
        ntests++;
        if (out_valid !== 1'b1) begin nfail++; $display("FAIL mid_prefill out_valid=%b exp=1", out_valid); end
        rst = 1'b1;
        step();
        ntests++;
        if (out_valid !== 1'b0 || res !== 19'h0) begin
            nfail++; $display("FAIL mid_reset valid=%b regs=%h exp=0/0", out_valid, res);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            if (out_valid !== 1'b0) stray++;
            step();
        end
        ntests++;
        if (stray != 0) begin nfail++; $display("FAIL mid_stale stray_cycles=%0d exp=0", stray); end
    endtask

    task automatic test_random();
        logic [18:0] q [$];
        logic [18:0] e;
        logic [15:0] d;
        int   sent = 0;
        int   got  = 0;
        int   bad  = 0;
        logic hold = 1'b0;
        logic acc;
        for (int cyc = 0; cyc < 60000 && got < 10000; cyc++) begin
            if (!hold) begin
                if (sent < 10000 && ($urandom % 4) != 0) begin
                    in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = (($urandom % 4) != 0);
            #1;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                ntests++;
                if (q.size() == 0) begin
                    nfail++; $display("FAIL rand_extra got=%h", res);
                end else begin
                    e = q.pop_front();
                    if (res !== e) begin
                        nfail++;
                        if (bad < 10) $display("FAIL rand_result idx%0d got=%h exp=%h", got, res, e);
                        bad++;
                    end
                end
                got++;
            end
            acc = in_valid & in_ready;
            if (acc) begin
                d = a - b;
                q.push_back({d, a < b, (a[15] != b[15]) && (d[15] != a[15]), d == 16'h0});
                sent++;
            end
            hold = in_valid & ~acc;
            step();
        end
        ntests++;
        if (got != 10000 || q.size() != 0) begin
            nfail++; $display("FAIL rand_count got=%0d pending=%0d exp=10000/0", got, q.size());
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
